// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: request, refill, hit-result and miss-report signals.
// The requester/memory side uses master; fetch_unit uses slave.
interface fetch_unit_if #(
    parameter int TAG_W    = 51,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 5,
    parameter int LINE_W   = 256,
    parameter int INSTR_W  = 32
);
    // Request side
    logic                  flushPipleine_i;
    logic                  enable_i;
    logic [0:TAG_W-1]      tag_i;
    logic [0:INDEX_W-1]    index_i;
    logic [0:OFFSET_W-1]   offset_i;

    // Refill side
    logic [0:TAG_W-1]      newTag_i;
    logic [0:INDEX_W-1]    newIndex_i;
    logic [0:OFFSET_W-1]   newOffset_i;
    logic [0:LINE_W-1]     newCacheline_i;
    logic                  cacheUpdateEnable_i;

    // Hit result towards decode
    logic [0:TAG_W-1]      tag_o;
    logic [0:INDEX_W-1]    index_o;
    logic [0:OFFSET_W-1]   offset_o;
    logic [0:INSTR_W-1]    fetchedInstruction_o;
    logic                  enable_o;

    // Miss report towards memory
    logic [0:TAG_W-1]      newTag_o;
    logic [0:INDEX_W-1]    newIndex_o;
    logic [0:OFFSET_W-1]   newOffset_o;
    logic                  isCacheMiss_o;

    modport master (
        output flushPipleine_i, enable_i, tag_i, index_i, offset_i,
        output newTag_i, newIndex_i, newOffset_i, newCacheline_i, cacheUpdateEnable_i,
        input  tag_o, index_o, offset_o, fetchedInstruction_o, enable_o,
        input  newTag_o, newIndex_o, newOffset_o, isCacheMiss_o
    );

    modport slave (
        input  flushPipleine_i, enable_i, tag_i, index_i, offset_i,
        input  newTag_i, newIndex_i, newOffset_i, newCacheline_i, cacheUpdateEnable_i,
        output tag_o, index_o, offset_o, fetchedInstruction_o, enable_o,
        output newTag_o, newIndex_o, newOffset_o, isCacheMiss_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Three-stage instruction fetch over a direct-mapped L1 I-cache (2^INDEX_W lines).
// Define FETCHUNIT_UPDATE_FORWARD_EN to forward a same-edge refill into the tag/data read.
module fetch_unit #(
    parameter int TAG_W    = 51,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 5,
    parameter int LINE_W   = 256,
    parameter int INSTR_W  = 32
) (
    input logic          clock_i,
    input logic          reset_i,
    fetch_unit_if.slave  bus
);
    localparam int NUM_LINES = 1 << INDEX_W;
    localparam int WORDS     = LINE_W / INSTR_W;
    localparam int WSEL_W    = $clog2(WORDS);

    // Cache storage
    logic [NUM_LINES-1:0] r_valid;
    logic [0:TAG_W-1]     r_tag_mem  [NUM_LINES];
    logic [0:LINE_W-1]    r_data_mem [NUM_LINES];

    // Stage 1: captured request
    logic                 r_s1_vld;
    logic [0:TAG_W-1]     r_s1_tag;
    logic [0:INDEX_W-1]   r_s1_index;
    logic [0:OFFSET_W-1]  r_s1_offset;

    // Stage 2: request plus the line read for it
    logic                 r_s2_vld;
    logic [0:TAG_W-1]     r_s2_tag;
    logic [0:INDEX_W-1]   r_s2_index;
    logic [0:OFFSET_W-1]  r_s2_offset;
    logic                 r_s2_line_vld;
    logic [0:TAG_W-1]     r_s2_line_tag;
    logic [0:LINE_W-1]    r_s2_line_data;

    logic                 w_rd_vld;
    logic [0:TAG_W-1]     w_rd_tag;
    logic [0:LINE_W-1]    w_rd_data;
    logic                 w_hit;
    logic [0:WSEL_W-1]    w_word_sel;
    logic [0:INSTR_W-1]   w_words [WORDS];
    logic [0:INSTR_W-1]   w_instr;
    logic                 w_unused;

    // The refill offset carries no information: whole lines are written.
    assign w_unused = ^bus.newOffset_i;

    // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clock_i) begin
        if (bus.cacheUpdateEnable_i) begin
            r_tag_mem[bus.newIndex_i]  <= bus.newTag_i;
            r_data_mem[bus.newIndex_i] <= bus.newCacheline_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid <= '0;
        end else if (bus.cacheUpdateEnable_i) begin
            r_valid[bus.newIndex_i] <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        w_rd_vld  = r_valid[r_s1_index];
        w_rd_tag  = r_tag_mem[r_s1_index];
        w_rd_data = r_data_mem[r_s1_index];
`ifdef FETCHUNIT_UPDATE_FORWARD_EN
        if (bus.cacheUpdateEnable_i && (bus.newIndex_i == r_s1_index)) begin
            w_rd_vld  = 1'b1;
            w_rd_tag  = bus.newTag_i;
            w_rd_data = bus.newCacheline_i;
        end
`endif
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_s1_vld       <= 1'b0;
            r_s1_tag       <= '0;
            r_s1_index     <= '0;
            r_s1_offset    <= '0;
            r_s2_vld       <= 1'b0;
            r_s2_tag       <= '0;
            r_s2_index     <= '0;
            r_s2_offset    <= '0;
            r_s2_line_vld  <= 1'b0;
            r_s2_line_tag  <= '0;
            r_s2_line_data <= '0;
        end else begin
            r_s1_vld <= bus.enable_i && !bus.flushPipleine_i;
            if (bus.enable_i) begin
                r_s1_tag    <= bus.tag_i;
                r_s1_index  <= bus.index_i;
                r_s1_offset <= bus.offset_i;
            end

            r_s2_vld       <= r_s1_vld && !bus.flushPipleine_i;
            r_s2_tag       <= r_s1_tag;
            r_s2_index     <= r_s1_index;
            r_s2_offset    <= r_s1_offset;
            r_s2_line_vld  <= w_rd_vld;
            r_s2_line_tag  <= w_rd_tag;
            r_s2_line_data <= w_rd_data;
        end
    end

    // Word 0 occupies the most significant bits of the line.
    always_comb begin
        for (int w = 0; w < WORDS; w++) begin
            w_words[w] = r_s2_line_data[w*INSTR_W +: INSTR_W];
        end
    end

    assign w_word_sel = r_s2_offset[0:WSEL_W-1];
    assign w_instr    = w_words[w_word_sel];
    assign w_hit      = r_s2_line_vld && (r_s2_line_tag == r_s2_tag);

    // Result stage: pulses last one cycle, payload registers hold between results.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            bus.enable_o             <= 1'b0;
            bus.isCacheMiss_o        <= 1'b0;
            bus.tag_o                <= '0;
            bus.index_o              <= '0;
            bus.offset_o             <= '0;
            bus.fetchedInstruction_o <= '0;
            bus.newTag_o             <= '0;
            bus.newIndex_o           <= '0;
            bus.newOffset_o          <= '0;
        end else begin
            bus.enable_o      <= 1'b0;
            bus.isCacheMiss_o <= 1'b0;
            if (r_s2_vld && !bus.flushPipleine_i) begin
                if (w_hit) begin
                    bus.enable_o             <= 1'b1;
                    bus.tag_o                <= r_s2_tag;
                    bus.index_o              <= r_s2_index;
                    bus.offset_o             <= r_s2_offset;
                    bus.fetchedInstruction_o <= w_instr;
                end else begin
                    bus.isCacheMiss_o <= 1'b1;
                    bus.newTag_o      <= r_s2_tag;
                    bus.newIndex_o    <= r_s2_index;
                    bus.newOffset_o   <= r_s2_offset;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: miss, refill, pipelined hits, flush and async reset.
module tb_fetch_unit;
    logic clock_i;
    logic reset_i;
    int   n_checks;
    int   n_errors;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One-cycle request; returns at the negedge after the capturing edge.
    task automatic fetch_one(input logic [50:0] t, input logic [7:0] ix, input logic [4:0] of);
        @(negedge clock_i);
        bus.tag_i    = t;
        bus.index_i  = ix;
        bus.offset_i = of;
        bus.enable_i = 1'b1;
        @(negedge clock_i);
        bus.enable_i = 1'b0;
    endtask

    task automatic refill(input logic [50:0] t, input logic [7:0] ix, input logic [255:0] line);
        @(negedge clock_i);
        bus.newTag_i            = t;
        bus.newIndex_i          = ix;
        bus.newCacheline_i      = line;
        bus.cacheUpdateEnable_i = 1'b1;
        @(negedge clock_i);
        bus.cacheUpdateEnable_i = 1'b0;
    endtask

    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [31:0]  words_a [8];
    logic [4:0]   b2b_off [7];
    int           pulses;

    initial begin
        n_checks = 0;
        n_errors = 0;
        line_a = 256'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888;
        line_b = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_12345678;
        words_a = '{32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC,
                    32'hBBBBBBBB, 32'hAAAAAAAA, 32'h99999999, 32'h88888888};
        b2b_off = '{5'd0, 5'd4, 5'd8, 5'd16, 5'd20, 5'd24, 5'd28};

        reset_i                 = 1'b1;
        bus.flushPipleine_i     = 1'b0;
        bus.enable_i            = 1'b0;
        bus.tag_i               = '0;
        bus.index_i             = '0;
        bus.offset_i            = '0;
        bus.newTag_i            = '0;
        bus.newIndex_i          = '0;
        bus.newOffset_i         = '0;
        bus.newCacheline_i      = '0;
        bus.cacheUpdateEnable_i = 1'b0;

        repeat (3) @(negedge clock_i);
        check("rst_enable_o", 256'(bus.enable_o), 256'd0);
        check("rst_miss_o",   256'(bus.isCacheMiss_o), 256'd0);
        check("rst_instr_o",  256'(bus.fetchedInstruction_o), 256'd0);
        check("rst_newtag_o", 256'(bus.newTag_o), 256'd0);
        reset_i = 1'b0;

        // Cold miss
        fetch_one(51'd5, 8'd8, 5'd4);
        repeat (2) @(negedge clock_i);
        check("miss1_miss",   256'(bus.isCacheMiss_o), 256'd1);
        check("miss1_enable", 256'(bus.enable_o), 256'd0);
        check("miss1_tag",    256'(bus.newTag_o), 256'd5);
        check("miss1_index",  256'(bus.newIndex_o), 256'd8);
        check("miss1_offset", 256'(bus.newOffset_o), 256'd4);
        @(negedge clock_i);
        check("miss1_pulse",  256'(bus.isCacheMiss_o), 256'd0);
        check("miss1_hold",   256'(bus.newTag_o), 256'd5);

        // Refill then hit
        refill(51'd5, 8'd8, line_a);
        fetch_one(51'd5, 8'd8, 5'd8);
        repeat (2) @(negedge clock_i);
        check("hit1_enable", 256'(bus.enable_o), 256'd1);
        check("hit1_miss",   256'(bus.isCacheMiss_o), 256'd0);
        check("hit1_instr",  256'(bus.fetchedInstruction_o), 256'hDDDDDDDD);
        check("hit1_tag",    256'(bus.tag_o), 256'd5);
        check("hit1_offset", 256'(bus.offset_o), 256'd8);

        // Back-to-back fetches, one result per cycle
        for (int c = 0; c < 10; c++) begin
            @(negedge clock_i);
            if (c >= 3) begin
                check($sformatf("b2b_en_%0d", c - 3), 256'(bus.enable_o), 256'd1);
                check($sformatf("b2b_instr_%0d", c - 3), 256'(bus.fetchedInstruction_o),
                      256'(words_a[b2b_off[c-3] >> 2]));
                check($sformatf("b2b_off_%0d", c - 3), 256'(bus.offset_o), 256'(b2b_off[c-3]));
            end
            if (c < 7) begin
                bus.tag_i    = 51'd5;
                bus.index_i  = 8'd8;
                bus.offset_i = b2b_off[c];
                bus.enable_i = 1'b1;
            end else begin
                bus.enable_i = 1'b0;
            end
        end
        @(negedge clock_i);
        check("b2b_end_en", 256'(bus.enable_o), 256'd0);

        // Tag mismatch on a valid line
        fetch_one(51'd6, 8'd8, 5'd12);
        repeat (2) @(negedge clock_i);
        check("miss2_miss",     256'(bus.isCacheMiss_o), 256'd1);
        check("miss2_enable",   256'(bus.enable_o), 256'd0);
        check("miss2_tag",      256'(bus.newTag_o), 256'd6);
        check("miss2_offset",   256'(bus.newOffset_o), 256'd12);
        check("miss2_hold_off", 256'(bus.offset_o), 256'd28);
        fetch_one(51'd5, 8'd8, 5'd0);
        repeat (2) @(negedge clock_i);
        check("retain_instr", 256'(bus.fetchedInstruction_o), 256'hFFFFFFFF);
        check("retain_en",    256'(bus.enable_o), 256'd1);

        // Refill of a line at the same edge stage 1 reads it
        @(negedge clock_i);
        bus.tag_i    = 51'd3;
        bus.index_i  = 8'd9;
        bus.offset_i = 5'd0;
        bus.enable_i = 1'b1;
        @(negedge clock_i);
        bus.enable_i            = 1'b0;
        bus.newTag_i            = 51'd3;
        bus.newIndex_i          = 8'd9;
        bus.newCacheline_i      = line_b;
        bus.cacheUpdateEnable_i = 1'b1;
        @(negedge clock_i);
        bus.cacheUpdateEnable_i = 1'b0;
        @(negedge clock_i);
`ifdef FETCHUNIT_UPDATE_FORWARD_EN
        check("fwd_enable", 256'(bus.enable_o), 256'd1);
        check("fwd_instr",  256'(bus.fetchedInstruction_o), 256'h11111111);
`else
        check("nofwd_miss",   256'(bus.isCacheMiss_o), 256'd1);
        check("nofwd_enable", 256'(bus.enable_o), 256'd0);
`endif
        fetch_one(51'd3, 8'd9, 5'd28);
        repeat (2) @(negedge clock_i);
        check("line9_instr", 256'(bus.fetchedInstruction_o), 256'h12345678);

        // Flush: two in-flight fetches plus a same-cycle request are dropped
        @(negedge clock_i);
        bus.tag_i = 51'd5; bus.index_i = 8'd8; bus.offset_i = 5'd0; bus.enable_i = 1'b1;
        @(negedge clock_i);
        bus.offset_i = 5'd4;
        @(negedge clock_i);
        bus.tag_i = 51'd7;
        bus.flushPipleine_i = 1'b1;
        @(negedge clock_i);
        bus.enable_i = 1'b0;
        bus.flushPipleine_i = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.enable_o || bus.isCacheMiss_o) pulses++;
            @(negedge clock_i);
        end
        check("flush_pulses", 256'(pulses), 256'd0);
        fetch_one(51'd5, 8'd8, 5'd12);
        repeat (2) @(negedge clock_i);
        check("flush_keep_en",    256'(bus.enable_o), 256'd1);
        check("flush_keep_instr", 256'(bus.fetchedInstruction_o), 256'hCCCCCCCC);

        // Asynchronous reset mid-cycle
        @(posedge clock_i);
        #2 reset_i = 1'b1;
        #1;
        check("arst_tag_o",   256'(bus.tag_o), 256'd0);
        check("arst_instr_o", 256'(bus.fetchedInstruction_o), 256'd0);
        check("arst_newtag",  256'(bus.newTag_o), 256'd0);
        check("arst_enable",  256'(bus.enable_o), 256'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        fetch_one(51'd5, 8'd8, 5'd8);
        repeat (2) @(negedge clock_i);
        check("post_rst_miss",   256'(bus.isCacheMiss_o), 256'd1);
        check("post_rst_enable", 256'(bus.enable_o), 256'd0);
        check("post_rst_tag",    256'(bus.newTag_o), 256'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
